// File: rtl/seg_bus_arbiter.sv
// Two-master round-robin arbiter for the seven-segment peripheral's STB/WE/ACK slave port.
// Define SEG_ARB_TIMEOUT_EN to enable the watchdog that aborts transactions never acknowledged.
module seg_bus_arbiter #(
  parameter int unsigned TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        m0_stb,
  input  logic        m0_we,
  input  logic [31:0] m0_dat_i,
  output logic [31:0] m0_dat_o,
  output logic        m0_ack,
  output logic        m0_err,
  input  logic        m1_stb,
  input  logic        m1_we,
  input  logic [31:0] m1_dat_i,
  output logic [31:0] m1_dat_o,
  output logic        m1_ack,
  output logic        m1_err,
  output logic        s_stb,
  output logic        s_we,
  output logic [31:0] s_dat_o,
  input  logic [31:0] s_dat_i,
  input  logic        s_ack,
  output logic [1:0]  grant
);

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

  state_t      state_q, state_d;
  logic [1:0]  grant_q, grant_d;
  logic        last_q, last_d;
  logic        sel_stb_s;
  logic        sel_we_s;
  logic [31:0] sel_dat_s;
  logic        timeout_s;

  if (TIMEOUT < 1 || TIMEOUT > 255) begin : g_bad_timeout
    $error("seg_bus_arbiter: TIMEOUT must be in 1..255");
  end

  // Route the owning master's request onto the slave side; an idle bus is fully quiet.
  always_comb begin
    sel_stb_s = 1'b0;
    sel_we_s  = 1'b0;
    sel_dat_s = 32'd0;
    if (grant_q[0]) begin
      sel_stb_s = m0_stb;
      sel_we_s  = m0_we;
      sel_dat_s = m0_dat_i;
    end else if (grant_q[1]) begin
      sel_stb_s = m1_stb;
      sel_we_s  = m1_we;
      sel_dat_s = m1_dat_i;
    end else begin
      sel_stb_s = 1'b0;
      sel_we_s  = 1'b0;
      sel_dat_s = 32'd0;
    end
  end

  assign s_stb    = sel_stb_s;
  assign s_we     = sel_we_s;
  assign s_dat_o  = sel_dat_s;
  assign grant    = grant_q;
  assign m0_ack   = grant_q[0] & s_ack;
  assign m1_ack   = grant_q[1] & s_ack;
  assign m0_dat_o = grant_q[0] ? s_dat_i : 32'd0;
  assign m1_dat_o = grant_q[1] ? s_dat_i : 32'd0;

  // Arbitration and completion; ack outranks abort, which outranks the watchdog.
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    last_d  = last_q;
    case (state_q)
      IDLE: begin
        if (m0_stb && m1_stb) begin
          state_d = BUSY;
          grant_d = last_q ? 2'b01 : 2'b10;
        end else if (m0_stb) begin
          state_d = BUSY;
          grant_d = 2'b01;
        end else if (m1_stb) begin
          state_d = BUSY;
          grant_d = 2'b10;
        end else begin
          state_d = IDLE;
          grant_d = 2'b00;
        end
      end
      BUSY: begin
        if (s_ack) begin
          state_d = IDLE;
          grant_d = 2'b00;
          last_d  = grant_q[1];
        end else if (!sel_stb_s) begin
          state_d = IDLE;
          grant_d = 2'b00;
        end else if (timeout_s) begin
          state_d = IDLE;
          grant_d = 2'b00;
          last_d  = grant_q[1];
        end else begin
          state_d = BUSY;
        end
      end
      default: begin
        state_d = IDLE;
        grant_d = 2'b00;
      end
    endcase
  end

  // FSM state, owner and round-robin pointer; m0 wins the first tie after reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      grant_q <= 2'b00;
      last_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
    end
  end

`ifdef SEG_ARB_TIMEOUT_EN
  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  logic [7:0] cnt_q, cnt_d;
  logic [1:0] err_q, err_d;

  assign timeout_s = (cnt_q == CNT_LAST);

  // Watchdog: count unacknowledged BUSY cycles and flag the owner when the budget runs out.
  always_comb begin
    cnt_d = cnt_q;
    err_d = 2'b00;
    if (state_q == IDLE) begin
      cnt_d = 8'd0;
    end else if (s_ack) begin
      cnt_d = cnt_q;
    end else begin
      cnt_d = cnt_q + 8'd1;
      if (sel_stb_s && timeout_s) begin
        err_d = grant_q;
      end else begin
        err_d = 2'b00;
      end
    end
  end

  // Watchdog counter and one-cycle error pulse registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= 8'd0;
      err_q <= 2'b00;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end

  assign m0_err = err_q[0];
  assign m1_err = err_q[1];
`else
  assign timeout_s = 1'b0;
  assign m0_err    = 1'b0;
  assign m1_err    = 1'b0;
`endif

endmodule

// File: tb/tb_seg_bus_arbiter.sv
// Bench for seg_bus_arbiter: directed scenarios plus random traffic against a transaction-level model.
// Define SEG_ARB_TIMEOUT_EN for both bench and RTL to exercise the watchdog with TIMEOUT=4.
module tb_seg_bus_arbiter;

`ifdef SEG_ARB_TIMEOUT_EN
  localparam int TMO    = 4;
  localparam bit TMO_EN = 1'b1;
`else
  localparam int TMO    = 15;
  localparam bit TMO_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        m0_stb, m0_we, m1_stb, m1_we;
  logic [31:0] m0_dat_i, m1_dat_i, m0_dat_o, m1_dat_o;
  logic        m0_ack, m1_ack, m0_err, m1_err;
  logic        s_stb, s_we, s_ack;
  logic [31:0] s_dat_o, s_dat_i;
  logic [1:0]  grant;

  seg_bus_arbiter #(.TIMEOUT(TMO)) dut (
    .clk(clk), .reset(reset),
    .m0_stb(m0_stb), .m0_we(m0_we), .m0_dat_i(m0_dat_i), .m0_dat_o(m0_dat_o),
    .m0_ack(m0_ack), .m0_err(m0_err),
    .m1_stb(m1_stb), .m1_we(m1_we), .m1_dat_i(m1_dat_i), .m1_dat_o(m1_dat_o),
    .m1_ack(m1_ack), .m1_err(m1_err),
    .s_stb(s_stb), .s_we(s_we), .s_dat_o(s_dat_o), .s_dat_i(s_dat_i), .s_ack(s_ack),
    .grant(grant)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Transaction-level model: who owns the bus, who was served last, how long the owner has waited.
  int owner;
  int last_srv;
  int waited;
  int err_who;
  bit done0, done1;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic req_of(input int k);
    return (k == 0) ? m0_stb : m1_stb;
  endfunction

  task automatic model_reset();
    owner    = -1;
    last_srv = 1;
    waited   = 0;
    err_who  = -1;
  endtask

  task automatic model_edge();
    err_who = -1;
    if (owner < 0) begin
      if (m0_stb && m1_stb) owner = 1 - last_srv;
      else if (m0_stb)      owner = 0;
      else if (m1_stb)      owner = 1;
      waited = 0;
    end else if (s_ack) begin
      last_srv = owner;
      owner    = -1;
    end else if (!req_of(owner)) begin
      owner = -1;
    end else if (TMO_EN && waited == TMO - 1) begin
      err_who  = owner;
      last_srv = owner;
      owner    = -1;
    end else begin
      waited++;
    end
  endtask

  task automatic check_all();
    logic [31:0] e_dat;
    if (reset) model_reset();
    e_dat = 32'd0;
    if (owner == 0) e_dat = m0_dat_i;
    if (owner == 1) e_dat = m1_dat_i;
    check_eq("grant",    32'(grant),  (owner < 0) ? 32'd0 : (32'd1 << owner));
    check_eq("s_stb",    32'(s_stb),  (owner < 0) ? 32'd0 : 32'(req_of(owner)));
    check_eq("s_we",     32'(s_we),   (owner == 0) ? 32'(m0_we) : (owner == 1) ? 32'(m1_we) : 32'd0);
    check_eq("s_dat_o",  s_dat_o,     e_dat);
    check_eq("m0_ack",   32'(m0_ack), 32'(owner == 0 && s_ack));
    check_eq("m1_ack",   32'(m1_ack), 32'(owner == 1 && s_ack));
    check_eq("m0_dat_o", m0_dat_o,    (owner == 0) ? s_dat_i : 32'd0);
    check_eq("m1_dat_o", m1_dat_o,    (owner == 1) ? s_dat_i : 32'd0);
    check_eq("m0_err",   32'(m0_err), 32'(err_who == 0));
    check_eq("m1_err",   32'(m1_err), 32'(err_who == 1));
  endtask

  // One clock cycle: compare settled outputs with the model, then advance both across the edge.
  task automatic tick();
    bit fin0, fin1;
    #1;
    check_all();
    fin0 = (owner == 0) && s_ack;
    fin1 = (owner == 1) && s_ack;
    @(posedge clk);
    if (reset) model_reset();
    else model_edge();
    #1;
    done0 = fin0;
    done1 = fin1;
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  logic [1:0] alt_exp [8];

  initial begin
    alt_exp = '{2'b01, 2'b00, 2'b10, 2'b00, 2'b01, 2'b00, 2'b10, 2'b00};
    reset = 1'b1;
    m0_stb = 1'b1; m0_we = 1'b1; m0_dat_i = 32'h0000_1234;
    m1_stb = 1'b0; m1_we = 1'b0; m1_dat_i = 32'h0;
    s_ack = 1'b0; s_dat_i = 32'h0;
    model_reset();
    done0 = 1'b0; done1 = 1'b0;

    // Reset held with m0 requesting, then first grant.
    tick();
    check_eq("rst_grant", 32'(grant), 32'd0);
    check_eq("rst_s_stb", 32'(s_stb), 32'd0);
    reset = 1'b0;
    tick();
    check_eq("first_grant", 32'(grant), 32'd1);
    check_eq("first_s_stb", 32'(s_stb), 32'd1);
    check_eq("first_s_dat", s_dat_o, 32'h0000_1234);

    // Continuous requests from both with a zero-wait slave alternate owners.
    pulse_reset();
    m0_stb = 1'b1; m1_stb = 1'b1; s_ack = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      check_eq("alt_grant", 32'(grant), 32'(alt_exp[i]));
    end

    // m1 read returns slave data to m1 only.
    m0_stb = 1'b0; m1_stb = 1'b0; s_ack = 1'b0;
    pulse_reset();
    m1_stb = 1'b1; m1_we = 1'b0;
    tick();
    s_dat_i = 32'h0000_00C0; s_ack = 1'b1;
    #1;
    check_eq("rd_m1_dat", m1_dat_o, 32'h0000_00C0);
    check_eq("rd_m1_ack", 32'(m1_ack), 32'd1);
    check_eq("rd_m0_dat", m0_dat_o, 32'd0);
    check_eq("rd_m0_ack", 32'(m0_ack), 32'd0);
    tick();
    m1_stb = 1'b0; s_ack = 1'b0;

    // Master abort leaves the round-robin pointer alone.
    pulse_reset();
    m0_stb = 1'b1;
    tick();
    m0_stb = 1'b0;
    tick();
    check_eq("abort_grant", 32'(grant), 32'd0);
    check_eq("abort_ack", 32'(m0_ack), 32'd0);
    m0_stb = 1'b1; m1_stb = 1'b1;
    tick();
    check_eq("abort_rewin", 32'(grant), 32'd1);

    // Unacknowledged transaction with m1 waiting.
    pulse_reset();
    m0_stb = 1'b1; m1_stb = 1'b1; s_ack = 1'b0;
    tick();
`ifdef SEG_ARB_TIMEOUT_EN
    for (int i = 0; i < TMO; i++) begin
      check_eq("wd_stb_hi", 32'(s_stb), 32'd1);
      check_eq("wd_err_lo", 32'(m0_err), 32'd0);
      tick();
    end
    check_eq("wd_stb_lo", 32'(s_stb), 32'd0);
    check_eq("wd_err_hi", 32'(m0_err), 32'd1);
    check_eq("wd_idle", 32'(grant), 32'd0);
    m0_stb = 1'b0;
    tick();
    check_eq("wd_m1_gnt", 32'(grant), 32'd2);
    check_eq("wd_err_1cy", 32'(m0_err), 32'd0);
`else
    for (int i = 0; i < 20; i++) begin
      check_eq("nowd_stb", 32'(s_stb), 32'd1);
      check_eq("nowd_err", 32'(m0_err), 32'd0);
      tick();
    end
`endif
    m0_stb = 1'b0; m1_stb = 1'b0;
    tick();

    // Asynchronous reset in the middle of a transaction.
    pulse_reset();
    m0_stb = 1'b1;
    tick();
    s_ack = 1'b1;
    #1;
    check_eq("mid_ack_pre", 32'(m0_ack), 32'd1);
    reset = 1'b1;
    #1;
    check_eq("mid_rst_stb", 32'(s_stb), 32'd0);
    check_eq("mid_rst_gnt", 32'(grant), 32'd0);
    check_eq("mid_rst_ack", 32'(m0_ack), 32'd0);
    tick();
    reset = 1'b0;
    s_ack = 1'b0; m0_stb = 1'b0;

    // Random traffic: masters hold requests until served, occasionally aborting.
    for (int c = 0; c < 600; c++) begin
      if (m0_stb && !done0 && err_who != 0) m0_stb = ($urandom_range(0, 99) >= 3);
      else m0_stb = $urandom_range(0, 1) != 0;
      if (m1_stb && !done1 && err_who != 1) m1_stb = ($urandom_range(0, 99) >= 3);
      else m1_stb = $urandom_range(0, 1) != 0;
      m0_we    = $urandom_range(0, 1) != 0;
      m1_we    = $urandom_range(0, 1) != 0;
      m0_dat_i = $urandom;
      m1_dat_i = $urandom;
      s_dat_i  = $urandom;
      s_ack    = ($urandom_range(0, 99) < 30);
      reset    = ($urandom_range(0, 199) == 0);
      tick();
      reset = 1'b0;
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
